// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider for the EX stage.
// Runs DIV (signed) and DIVU. It holds the pipeline through stall_o while it
// iterates, then delivers {remainder, quotient} on result_o with ready_o high.
// Optional feature macro: DIV_FAST_ZERO_EN. When it is defined, a zero divisor
// completes in one cycle with the same divide-by-zero result that the full
// iteration would produce.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [31:0] dividend_r;   // shifts left; quotient bits enter at the LSB
    logic [31:0] divisor_r;
    logic [31:0] rem_r;
    logic [4:0]  count_r;
    logic        signed_r;
    logic        sign1_r;
    logic        sign2_r;
    logic [63:0] result_r;

    logic [32:0] partial_s;
    logic        fits_s;
    logic [31:0] rem_next_s;
    logic [31:0] quot_next_s;
    logic        last_iter_s;
    logic        accept_s;
    logic        neg_q_s;
    logic        neg_r_s;

    // Two's-complement magnitude, taken only for signed operations.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic en);
        logic [31:0] m;
        if (en && v[31]) begin
            m = 32'd0 - v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Applies the quotient and remainder sign corrections and packs {rem, quot}.
    function automatic logic [63:0] sign_fix(input logic [31:0] q, input logic [31:0] r,
                                             input logic neg_q, input logic neg_r);
        logic [31:0] qf;
        logic [31:0] rf;
        qf = neg_q ? (32'd0 - q) : q;
        rf = neg_r ? (32'd0 - r) : r;
        return {rf, qf};
    endfunction

    // One restoring iteration: shift in the next dividend bit, then trial-subtract.
    always_comb begin
        partial_s   = {rem_r, dividend_r[31]};
        fits_s      = (partial_s >= {1'b0, divisor_r});
        // The true difference is below the divisor, so 32 bits are enough.
        rem_next_s  = fits_s ? (partial_s[31:0] - divisor_r) : partial_s[31:0];
        quot_next_s = {dividend_r[30:0], fits_s};
        last_iter_s = (count_r == 5'd31);
        accept_s    = (state_r == ST_IDLE) && start_i && !annul_i;
        neg_q_s     = signed_r && (sign1_r ^ sign2_r);
        neg_r_s     = signed_r && sign1_r;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; annul overrides everything, including completion.
    always_comb begin
        state_nxt_s = state_r;
        if (annul_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
`ifdef DIV_FAST_ZERO_EN
                        if (opdata2_i == 32'd0) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_BUSY;
                        end
`else
                        state_nxt_s = ST_BUSY;
`endif
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (last_iter_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // Same instruction still in EX while start_i stays high.
                    if (start_i) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: latch operands on accept, iterate in BUSY, register the fixed result.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dividend_r <= 32'd0;
            divisor_r  <= 32'd0;
            rem_r      <= 32'd0;
            count_r    <= 5'd0;
            signed_r   <= 1'b0;
            sign1_r    <= 1'b0;
            sign2_r    <= 1'b0;
            result_r   <= 64'd0;
        end else if (accept_s) begin
            dividend_r <= magnitude(opdata1_i, signed_i);
            divisor_r  <= magnitude(opdata2_i, signed_i);
            rem_r      <= 32'd0;
            count_r    <= 5'd0;
            signed_r   <= signed_i;
            sign1_r    <= opdata1_i[31];
            sign2_r    <= opdata2_i[31];
`ifdef DIV_FAST_ZERO_EN
            // Same result the full run gives: all-ones quotient, dividend as remainder.
            if (opdata2_i == 32'd0) begin
                result_r <= sign_fix(32'hFFFF_FFFF, magnitude(opdata1_i, signed_i),
                                     signed_i && opdata1_i[31], signed_i && opdata1_i[31]);
            end else begin
                result_r <= result_r;
            end
`endif
        end else if ((state_r == ST_BUSY) && !annul_i) begin
            rem_r      <= rem_next_s;
            dividend_r <= quot_next_s;
            count_r    <= count_r + 5'd1;
            if (last_iter_s) begin
                result_r <= sign_fix(quot_next_s, rem_next_s, neg_q_s, neg_r_s);
            end else begin
                result_r <= result_r;
            end
        end else begin
            result_r <= result_r;
        end
    end

    // Outputs: ready is a decode of the state register, the result is registered.
    always_comb begin
        ready_o  = (state_r == ST_DONE);
        result_o = result_r;
        stall_o  = start_i && !ready_o && !annul_i && resetn;
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes reference results, and a
// monitor pops and compares them on every rising edge of ready_o.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        annul_i = 1'b0;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = 64'd0;
    logic        ready_prev = 1'b0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .stall_o   (stall_o),
        .ready_o   (ready_o),
        .result_o  (result_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain integer division in 64-bit arithmetic, truncating toward zero.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [31:0] q32;
        if (b == 32'd0) begin
            q32 = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            return {a, q32};
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: compare each completion against the oldest expected result.
    always @(negedge clk) begin
        if (resetn && ready_o && !ready_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                check("result", result_o, exp_q.pop_front());
            end
        end
        ready_prev = ready_o;
    end

    // Issue one divide (caller sits just after a rising edge), hold start for
    // `hold` extra DONE cycles, then drop start; returns one edge later in IDLE.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] e;
        int cyc;
        int lat;
        int got;
        e = ref_div(sgn, a, b);
        exp_q.push_back(e);
        last_exp = e;
        lat = 33;
`ifdef DIV_FAST_ZERO_EN
        if (b == 32'd0) lat = 1;
`endif
        start_i = 1'b1;
        signed_i = sgn;
        opdata1_i = a;
        opdata2_i = b;
        cyc = 0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1;
                break;
            end
            if (stall_o) cyc++;
            @(posedge clk);
            #1;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
        end
        check("ready_seen", 64'(got), 64'd1);
        check("stall_cycles", 64'(cyc), 64'(lat));
        check("stall_at_done", {63'd0, stall_o}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("hold_ready", {63'd0, ready_o}, 64'd1);
            check("hold_result", result_o, e);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_drop", {63'd0, ready_o}, 64'd0);
    endtask

    // Start an unsigned divide and annul it once count reaches n.
    task automatic annul_at(input int n);
        start_i = 1'b1;
        signed_i = 1'b0;
        opdata1_i = $urandom;
        opdata2_i = $urandom | 32'd1;
        repeat (n + 1) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
        check("stall_during_annul", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        check("annul_stall", {63'd0, stall_o}, 64'd0);
        check("annul_result_kept", result_o, last_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          sel;

        // Reset with start high: stall must stay low while resetn is low.
        start_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {63'd0, stall_o}, 64'd0);
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_div(1'b0, 32'd100, 32'd7, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(1'b0, 32'h1234_5678, 32'd0, 0);
        run_div(1'b1, 32'hFFFF_FF00, 32'd0, 0);
        run_div(1'b1, 32'h0000_0123, 32'd0, 0);

        annul_at(10);
        run_div(1'b0, 32'd9, 32'd3, 0);

        // Hold start past DONE, then reissue after a single low cycle.
        run_div(1'b0, 32'd1000, 32'd33, 5);
        run_div(1'b0, 32'd77, 32'd5, 0);

        // Annul on the completion edge wins.
        annul_at(31);
        run_div(1'b1, 32'hFFFF_FF85, 32'd10, 0);

        // Reset mid-operation clears the result.
        start_i = 1'b1;
        signed_i = 1'b0;
        opdata1_i = 32'd500;
        opdata2_i = 32'd7;
        repeat (6) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check("midreset_ready", {63'd0, ready_o}, 64'd0);
        check("midreset_result", result_o, 64'd0);
        last_exp = 64'd0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Randomised divides with a bias towards the corner operands.
        for (int k = 0; k < 40; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = 32'hFFFF_FFFF;
                4: a = $urandom_range(0, 100);
                default: begin end
            endcase
            run_div(s, a, b, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EX stage, running alongside the single-cycle ALU. It executes DIV/DIVU with a radix-2 restoring algorithm and holds the pipeline with a stall request while it iterates. It delivers a 64-bit {remainder, quotient} word to the HI/LO write path: HI gets the remainder, LO gets the quotient.

## Interface
Parameters: none. All widths are fixed at 32-bit operands and a 64-bit result.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- resetn  in  1  synchronous, active-low reset
- start_i  in  1  divide request from EX decode; held high while the DIV instruction sits in EX
- signed_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- annul_i  in  1  pipeline flush (exception or ERET); abandons the current operation
- stall_o  out  1  stall request to the pipeline controller
- ready_o  out  1  result valid
- result_o  out  64  {remainder[63:32], quotient[31:0]}

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE**
  - If start_i=1 and annul_i=0: latch |opdata1_i|, |opdata2_i|, signed_i and both sign bits. Clear the partial remainder and set count=0. Go to BUSY.
  - Magnitudes are taken only when signed_i=1; for DIVU the operands are used raw.
- **BUSY**, one iteration per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial subtraction uses a 33-bit rem − divisor.
  - If the result is non-negative, the remainder takes the difference and the quotient bit is 1. Otherwise the quotient bit is 0.
  - count increments each cycle. After count=31 the state goes to DONE.
- **Sign fix**, applied on the BUSY→DONE edge:
  - The quotient is negated if signed_i=1 and the operand signs differ.
  - The remainder is negated if signed_i=1 and the dividend was negative.
  - The corrected value is registered into result_o.
- **DONE**
  - ready_o=1 and result_o is held.
  - The block stays in DONE while start_i=1, because the same instruction is still in EX.
  - When start_i=0 the state goes to IDLE and ready_o goes to 0.
  - A new start_i cannot be accepted in the cycle DONE is left. Back-to-back divides therefore need start_i low for at least one cycle.
- **annul_i=1** in any state forces IDLE on the next edge, with ready_o=0 and result_o unchanged. It takes priority over start_i.
- **stall_o** = start_i & ~ready_o & ~annul_i & resetn. It is combinational.
- **Divide by zero** yields the natural restoring result:
  - DIVU: quotient 0xFFFFFFFF, remainder equal to the dividend.
  - DIV with negative dividend: quotient 0x00000001, remainder equal to the dividend.
- **0x80000000 / −1** (signed): quotient 0x80000000, remainder 0. The magnitude 0x80000000 is represented correctly as unsigned, so no special case is needed.

## Timing
- Reset (resetn=0 at an edge) puts the block in IDLE with ready_o=0, result_o=0 and count=0. stall_o=0 while resetn=0.
- Reset mid-operation has the same effect as annul: the block goes to IDLE and the result is cleared.
- Start sampled at edge T:
  - BUSY on T+1 through T+32, 32 iterations.
  - DONE from T+33, with ready_o=1 and result_o valid.
  - stall_o is high for 33 cycles (T through T+32) and low from T+33.
- Operand changes after the start edge are ignored, since operands are latched.
- If annul_i and completion happen on the same edge, annul wins: the block goes to IDLE and ready_o stays 0.

## Configuration
- Macro: `DIV_FAST_ZERO_EN`.
- **Defined:** in IDLE, a start with opdata2_i==0 goes directly to DONE on the next edge, a latency of 1 cycle. It loads the same divide-by-zero result listed in Operation; only the latency changes.
- **Undefined:** a zero divisor runs the full 32 iterations.

## Test plan
- DIVU 100/7, start held → stall_o high 33 cycles. At T+33: ready_o=1, result_o={0x00000002, 0x0000000E}.
- DIV −7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0x00000000. No hang.
- DIVU 0x12345678 / 0 → result_o={0x12345678, 0xFFFFFFFF}:
  - with `DIV_FAST_ZERO_EN`: ready_o at T+1;
  - without: ready_o at T+33.
- Annul at BUSY count=10 → IDLE next edge, stall_o=0, ready_o=0. A new DIVU 9/3 issued afterwards returns {0, 3}.
- Hold start_i 5 cycles past DONE → ready_o and result_o stable throughout. Drop start_i → IDLE. Reissue after one low cycle → a second full 33-cycle stall.
